// File: rtl/pool_pkg.sv
// Shared definitions for the streaming pooling engine: mode encodings and
// width helpers used to size the accumulation datapath.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A KxK sum of BIT_WIDTH operands needs 2*log2(K) guard bits.
  function automatic int acc_width(input int bit_width, input int k);
    return bit_width + 2 * clog2(k);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Pairwise reduction operator: signed max in max mode, sum in average mode.
module pool_combine
  import pool_pkg::*;
#(
  parameter int ACC_W = 34
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  input  logic                    mode_i,
  output logic signed [ACC_W-1:0] y_o
);

  // NOTE: purely combinational; every path assigns y_o, so no latch is inferred.
  always_comb begin
    if (mode_i == POOL_AVG) y_o = a_i + b_i;
    else                    y_o = (a_i > b_i) ? a_i : b_i;
  end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming KxK non-overlapping max/average pooling over a raster-order
// feature map; column partials for the current window row band live in pbuf.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  input  logic                        mode,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic                        out_last
);

  localparam int LG    = clog2(K);
  localparam int ACC_W = acc_width(BIT_WIDTH, K);
  localparam int NCOL  = IMG_W / K;
  localparam int CW    = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
  localparam int RW    = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
  localparam int OCW   = (CW > LG) ? CW - LG : 1;

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  h_acc_q, h_acc_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic signed [ACC_W-1:0]  pbuf_q [NCOL];

  logic [LG-1:0]            wc, wr;
  logic [OCW-1:0]           oc;
  logic                     col_end, row_end, win_done, pbuf_we;
  logic signed [ACC_W-1:0]  pix_ext, h_comb, h_new, pbuf_rd, v, pbuf_wd, avg_sh;
  logic signed [BIT_WIDTH-1:0] result;

  pool_combine #(.ACC_W(ACC_W)) u_h_combine (
    .a_i    (h_acc_q),
    .b_i    (pix_ext),
    .mode_i (mode_q),
    .y_o    (h_comb)
  );

  pool_combine #(.ACC_W(ACC_W)) u_v_combine (
    .a_i    (pbuf_rd),
    .b_i    (h_new),
    .mode_i (mode_q),
    .y_o    (v)
  );

  always_comb begin
    wc       = col_q[LG-1:0];
    wr       = row_q[LG-1:0];
    oc       = OCW'(col_q >> LG);
    col_end  = (col_q == CW'(IMG_W - 1));
    row_end  = (row_q == RW'(IMG_H - 1));
    pix_ext  = {{(ACC_W - BIT_WIDTH){in_data[BIT_WIDTH-1]}}, in_data};
    h_new    = (wc == '0) ? pix_ext : h_comb;
    pbuf_rd  = pbuf_q[oc];
    win_done = in_valid && (wc == LG'(K - 1)) && (wr == LG'(K - 1));
    pbuf_we  = in_valid && (wc == LG'(K - 1)) && (wr != LG'(K - 1));
    pbuf_wd  = (wr == '0) ? h_new : v;
    // Arithmetic shift floors toward -inf, which is the intended average rounding.
    avg_sh   = v >>> (2 * LG);
    result   = (mode_q == POOL_AVG) ? BIT_WIDTH'(avg_sh) : BIT_WIDTH'(v);
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    h_acc_d     = h_acc_q;
    out_valid_d = win_done;
    out_data_d  = out_data_q;
    out_last_d  = win_done && col_end && row_end;
    if (in_valid) begin
      h_acc_d = h_new;
      if (col_q == '0 && row_q == '0) mode_d = mode;
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (win_done) out_data_d = result;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_MAX;
      h_acc_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      h_acc_q     <= h_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the partial buffer is deliberately not reset; each entry is written
  // on row wr==0 before any read, so a reset would only cost area and fanout.
  always_ff @(posedge clk) begin
    if (pbuf_we) pbuf_q[oc] <= pbuf_wd;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench: a 4x4 instance for directed cases and a default 28x28
// instance for back-to-back random frames, both checked cycle by cycle.
module tb_pool2d_stream;

  logic clk;
  logic rst;
  logic vld [2];
  logic signed [31:0] dat [2];
  logic md  [2];
  logic ov  [2];
  logic signed [31:0] od [2];
  logic ol  [2];

  int checks;
  int failures;

  pool2d_stream #(.BIT_WIDTH(32), .IMG_W(4), .IMG_H(4), .K(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .mode(md[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0])
  );

  pool2d_stream u_big (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .mode(md[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-frame pixel store, window reduced by plain loops.
  longint fr [2][28][28];
  int     pr [2];
  int     pc [2];
  logic   mf [2];
  int     mw [2] = '{4, 28};
  int     mh [2] = '{4, 28};
  logic   exp_v [2];
  longint exp_d [2];
  logic   exp_l [2];
  longint mq [$];

  logic   cv [2];
  longint cd [2];
  logic   cl [2];
  bit     mon_en;
  int     obs0 [$];
  int     obs1_n;
  int     last1_n;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, $signed(got), $signed(exp));
    end
  endtask

  task automatic model_pixel(input int d, input longint val, input logic m);
    longint acc, sum;
    if (pr[d] == 0 && pc[d] == 0) mf[d] = m;
    fr[d][pr[d]][pc[d]] = val;
    if ((pr[d] % 2 == 1) && (pc[d] % 2 == 1)) begin
      sum = 0;
      acc = fr[d][pr[d]-1][pc[d]-1];
      for (int r = pr[d] - 1; r <= pr[d]; r++)
        for (int c = pc[d] - 1; c <= pc[d]; c++) begin
          sum += fr[d][r][c];
          if (fr[d][r][c] > acc) acc = fr[d][r][c];
        end
      if (mf[d]) begin
        acc = sum / 4;
        if ((sum % 4 != 0) && (sum < 0)) acc = acc - 1;
      end
      exp_v[d] = 1'b1;
      exp_d[d] = acc;
      exp_l[d] = (pr[d] == mh[d] - 1) && (pc[d] == mw[d] - 1);
      if (d == 0) mq.push_back(acc);
    end
    if (pc[d] == mw[d] - 1) begin
      pc[d] = 0;
      pr[d] = (pr[d] == mh[d] - 1) ? 0 : pr[d] + 1;
    end else begin
      pc[d] = pc[d] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      vld[d]   = 1'b0;
      exp_v[d] = 1'b0;
      exp_l[d] = 1'b0;
    end
  endtask

  task automatic send(input int d, input int val, input logic m);
    tick();
    vld[d] = 1'b1;
    dat[d] = val;
    md[d]  = m;
    model_pixel(d, longint'(val), m);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      pr[d] = 0;
      pc[d] = 0;
      mf[d] = 1'b0;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic check_small(input string name, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({name, "_count"}, obs0.size(), 4);
    check({name, "_model_count"}, mq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs0.size()) check({name, "_dut"}, longint'(obs0[i]), longint'(e[i]));
      if (i < mq.size())   check({name, "_model"}, mq[i], longint'(e[i]));
    end
    obs0.delete();
    mq.delete();
  endtask

  // Compare process: capture what the model says was sampled at this edge,
  // then check the registered outputs half a cycle later.
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        cv[d] = exp_v[d];
        cd[d] = exp_d[d];
        cl[d] = exp_l[d];
      end
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          check("out_valid", ov[d], cv[d]);
          if (cv[d]) begin
            check("out_data", od[d], cd[d]);
            check("out_last", ol[d], cl[d]);
          end else begin
            check("out_last_idle", ol[d], 1'b0);
          end
          if (ov[d] === 1'b1) begin
            if (d == 0) obs0.push_back(od[d]);
            else obs1_n++;
          end
          if (d == 1 && ol[d] === 1'b1) last1_n++;
        end
      end
    end
  end

  initial begin
    int q [16];
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    obs1_n   = 0;
    last1_n  = 0;
    rst      = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; dat[d] = '0; md[d] = 1'b0;
      exp_v[d] = 1'b0; exp_d[d] = 0; exp_l[d] = 1'b0;
      pr[d] = 0; pc[d] = 0; mf[d] = 1'b0;
    end
    tick();
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_valid", ov[d], 1'b0);
      check("reset_data", od[d], 0);
      check("reset_last", ol[d], 1'b0);
    end
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Contiguous 0..15, max then average.
    for (int i = 0; i < 16; i++) send(0, i, 1'b0);
    tick(); tick();
    check_small("max_ramp", 5, 7, 13, 15);
    for (int i = 0; i < 16; i++) send(0, i, 1'b1);
    tick(); tick();
    check_small("avg_ramp", 2, 4, 10, 12);

    // Negative first window: average floors toward -inf.
    q = '{-1, -2, 0, 0, -3, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) send(0, q[i], 1'b1);
    tick(); tick();
    check_small("avg_neg", -3, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(0, q[i], 1'b0);
    tick(); tick();
    check_small("max_neg", -1, 0, 0, 0);

    // Random idle gaps between pixels.
    for (int i = 0; i < 16; i++) begin
      send(0, i, 1'b0);
      repeat ($urandom_range(0, 5)) tick();
    end
    tick(); tick();
    check_small("gaps", 5, 7, 13, 15);

    // Mid-frame reset, then a frame whose mode input flips after pixel 3.
    for (int i = 0; i < 7; i++) send(0, i, 1'b0);
    do_reset();
    tick();
    obs0.delete();
    mq.delete();
    for (int i = 0; i < 16; i++) send(0, i, (i > 3) ? 1'b1 : 1'b0);
    tick(); tick();
    check_small("post_reset", 5, 7, 13, 15);

    // Default geometry: two back-to-back random frames, max then average.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 784; i++) send(1, int'($urandom), f[0]);
    tick(); tick(); tick();
    check("big_outputs", obs1_n, 392);
    check("big_lasts", last1_n, 2);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
